// File: rtl/sdram_fsm_pkg.sv
// Shared SDRAM parameters (the sdram_para set): state codes, default timing
// constants and small helpers for the sdram_fsm sequencer.
package sdram_fsm_pkg;

  typedef enum logic [3:0] {
    I_NOP           = 4'd0,
    I_PRECHARGE     = 4'd1,
    I_TRP           = 4'd2,
    I_AUTO_REFRESH1 = 4'd3,
    I_TRF1          = 4'd4,
    I_AUTO_REFRESH2 = 4'd5,
    I_TRF2          = 4'd6,
    I_MRS           = 4'd7,
    I_TMRD          = 4'd8,
    I_DONE          = 4'd9
  } init_state_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TDAL   = 4'd8,
    W_AR     = 4'd9,
    W_TRFC   = 4'd10
  } work_state_t;

  localparam int unsigned DEF_T_POWERUP  = 20000;
  localparam int unsigned DEF_T_RP       = 2;
  localparam int unsigned DEF_T_RFC      = 7;
  localparam int unsigned DEF_T_MRD      = 2;
  localparam int unsigned DEF_T_RCD      = 2;
  localparam int unsigned DEF_CL         = 3;
  localparam int unsigned DEF_T_DAL      = 4;
  localparam int unsigned DEF_REF_PERIOD = 780;
  localparam int unsigned FAST_POWERUP   = 200;

  // A zero byte count stands for a full 512-word burst.
  function automatic logic [9:0] burst_len(input logic [8:0] bytes);
    return (bytes == 9'd0) ? 10'd512 : {1'b0, bytes};
  endfunction

  function automatic logic cnt_done(input logic [31:0] cnt, input int unsigned len);
    return cnt == 32'(len - 1);
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval counter and pending-refresh flag for sdram_fsm.
module sdram_ref_timer
  import sdram_fsm_pkg::*;
#(
  parameter int unsigned REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_pending
);

  logic [31:0] r_count;
  logic        r_pending;
  logic        w_expire;

  assign w_expire  = i_enable && (r_count == 32'(REF_PERIOD - 1));
  assign o_pending = r_pending;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_expire) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 32'd1;
    end
  end

  // Clearing only happens while pending is set, so an expiry on that same
  // edge is absorbed rather than queued.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end else if (w_expire) begin
      r_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_fsm.sv
// SDRAM master sequencer: power-up init, refresh/write/read arbitration and
// per-state cycle pacing. Define SDRAM_FAST_INIT_EN for a 200-cycle power-up wait.
module sdram_fsm
  import sdram_fsm_pkg::*;
#(
  parameter int unsigned T_POWERUP  = DEF_T_POWERUP,
  parameter int unsigned T_RP       = DEF_T_RP,
  parameter int unsigned T_RFC      = DEF_T_RFC,
  parameter int unsigned T_MRD      = DEF_T_MRD,
  parameter int unsigned T_RCD      = DEF_T_RCD,
  parameter int unsigned CL         = DEF_CL,
  parameter int unsigned T_DAL      = DEF_T_DAL,
  parameter int unsigned REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        sdram_wr_req,
  input  logic        sdram_rd_req,
  input  logic [8:0]  sdwr_bytes,
  input  logic [8:0]  sdrd_bytes,
  output logic [3:0]  init_state,
  output logic [3:0]  work_state,
  output logic [31:0] cnt_clk,
  output logic        sys_r_wn,
  output logic        sdram_init_done,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic        sdram_busy
);

`ifdef SDRAM_FAST_INIT_EN
  localparam int unsigned POWERUP_CYC = FAST_POWERUP;
`else
  localparam int unsigned POWERUP_CYC = T_POWERUP;
`endif

  init_state_t r_init_state, w_init_next;
  work_state_t r_work_state, w_work_next;
  logic [31:0] r_cnt_clk;
  logic        r_sys_r_wn;
  logic [9:0]  r_burst_len;
  logic        w_grant_wr;
  logic        w_grant_rd;
  logic        w_ref_pending;
  logic        w_ref_clear;
  logic        w_init_done;

  assign w_init_done     = (r_init_state == I_DONE);
  assign init_state      = r_init_state;
  assign work_state      = r_work_state;
  assign cnt_clk         = r_cnt_clk;
  assign sys_r_wn        = r_sys_r_wn;
  assign sdram_init_done = w_init_done;
  assign sdram_wr_ack    = (r_work_state == W_WD);
  assign sdram_rd_ack    = (r_work_state == W_RD);
  assign sdram_busy      = (r_work_state != W_IDLE) || !w_init_done;
  assign w_ref_clear     = (r_work_state == W_IDLE) && (w_work_next == W_AR);

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .clk_100m  (clk_100m),
    .rst_n     (rst_n),
    .i_enable  (w_init_done),
    .i_clear   (w_ref_clear),
    .o_pending (w_ref_pending)
  );

  always_comb begin
    w_init_next = r_init_state;
    unique case (r_init_state)
      I_NOP:           if (cnt_done(r_cnt_clk, POWERUP_CYC)) w_init_next = I_PRECHARGE;
      I_PRECHARGE:     w_init_next = I_TRP;
      I_TRP:           if (cnt_done(r_cnt_clk, T_RP)) w_init_next = I_AUTO_REFRESH1;
      I_AUTO_REFRESH1: w_init_next = I_TRF1;
      I_TRF1:          if (cnt_done(r_cnt_clk, T_RFC)) w_init_next = I_AUTO_REFRESH2;
      I_AUTO_REFRESH2: w_init_next = I_TRF2;
      I_TRF2:          if (cnt_done(r_cnt_clk, T_RFC)) w_init_next = I_MRS;
      I_MRS:           w_init_next = I_TMRD;
      I_TMRD:          if (cnt_done(r_cnt_clk, T_MRD)) w_init_next = I_DONE;
      I_DONE:          w_init_next = I_DONE;
      default:         w_init_next = I_NOP;
    endcase
  end

  // Refresh beats write beats read; a running transaction is never pre-empted.
  always_comb begin
    w_work_next = r_work_state;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    if (w_init_done) begin
      unique case (r_work_state)
        W_IDLE: begin
          if (w_ref_pending) begin
            w_work_next = W_AR;
          end else if (sdram_wr_req) begin
            w_work_next = W_ACTIVE;
            w_grant_wr  = 1'b1;
          end else if (sdram_rd_req) begin
            w_work_next = W_ACTIVE;
            w_grant_rd  = 1'b1;
          end
        end
        W_ACTIVE: w_work_next = W_TRCD;
        W_TRCD:   if (cnt_done(r_cnt_clk, T_RCD)) w_work_next = r_sys_r_wn ? W_WRITE : W_READ;
        W_WRITE:  w_work_next = W_WD;
        W_WD:     if (cnt_done(r_cnt_clk, {22'd0, r_burst_len})) w_work_next = W_TDAL;
        W_TDAL:   if (cnt_done(r_cnt_clk, T_DAL)) w_work_next = W_IDLE;
        W_READ:   w_work_next = W_CL;
        W_CL:     if (cnt_done(r_cnt_clk, CL - 1)) w_work_next = W_RD;
        W_RD:     if (cnt_done(r_cnt_clk, {22'd0, r_burst_len})) w_work_next = W_IDLE;
        W_AR:     w_work_next = W_TRFC;
        W_TRFC:   if (cnt_done(r_cnt_clk, T_RFC)) w_work_next = W_IDLE;
        default:  w_work_next = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_init_state <= I_NOP;
      r_work_state <= W_IDLE;
      r_cnt_clk    <= '0;
      r_sys_r_wn   <= 1'b0;
      r_burst_len  <= '0;
    end else begin
      r_init_state <= w_init_next;
      r_work_state <= w_work_next;
      if ((w_init_next != r_init_state) || (w_work_next != r_work_state)) begin
        r_cnt_clk <= '0;
      end else begin
        r_cnt_clk <= r_cnt_clk + 32'd1;
      end
      if (w_grant_wr) begin
        r_sys_r_wn  <= 1'b1;
        r_burst_len <= burst_len(sdwr_bytes);
      end else if (w_grant_rd) begin
        r_sys_r_wn  <= 1'b0;
        r_burst_len <= burst_len(sdrd_bytes);
      end
    end
  end

endmodule
